// File: rtl/tx_pkg.sv
// Shared types and constants for the TX DAC shaper: envelope states, unity
// envelope, dither LFSR constants and a signed saturation helper.
package tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UP   = 3'd1,
        ST_ON   = 3'd2,
        ST_DOWN = 3'd3,
        ST_HOLD = 3'd4
    } tx_state_t;

    localparam logic [16:0] ENV_ONE   = 17'h08000;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (state bits 15,13,12,10)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [33:0] sat_clip(input logic signed [33:0] x,
                                                    input int w);
        logic signed [33:0] hi;
        logic signed [33:0] lo;
        hi = (34'sd1 <<< (w - 1)) - 34'sd1;
        lo = -hi - 34'sd1;
        if (x > hi) begin
            sat_clip = hi;
        end else if (x < lo) begin
            sat_clip = lo;
        end else begin
            sat_clip = x;
        end
    endfunction

endpackage

// File: rtl/tx_env_gen.sv
// Burst envelope generator: IDLE/UP/ON/DOWN/HOLD state machine, Q1.15
// envelope ramp and burst sample counter. Advances only on sample strobes.
module tx_env_gen
    import tx_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic             tx_en,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [15:0]      ramp_inc,
    output logic [16:0]      env,
    output logic             busy,
    output logic             done
);

    tx_state_t        state_q, state_d;
    logic [16:0]      env_q, env_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             burst_done_q, burst_done_d;
    logic             done_q, done_d;

    logic [16:0]      sum_up;
    logic [16:0]      env_up;
    logic [16:0]      env_dn;
    logic             burst_hit;
    logic             go_down;
    logic             burst_end;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            env_q        <= 17'd0;
            cnt_q        <= '0;
            burst_done_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            env_q        <= env_d;
            cnt_q        <= cnt_d;
            burst_done_q <= burst_done_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        env_d        = env_q;
        cnt_d        = cnt_q;
        burst_done_d = burst_done_q;
        done_d       = 1'b0;
        go_down      = 1'b0;
        burst_end    = 1'b0;

        sum_up    = env_q + 17'(ramp_inc);
        env_up    = ((ramp_inc == 16'd0) || (sum_up >= ENV_ONE)) ? ENV_ONE : sum_up;
        env_dn    = ((ramp_inc == 16'd0) || (env_q <= 17'(ramp_inc))) ? 17'd0
                                                                      : env_q - 17'(ramp_inc);
        // >= so that shrinking burst_len below the running count ends the burst now
        burst_hit = (burst_len != '0) && (cnt_q >= burst_len - CNT_W'(1));

        if (sample_valid) begin
            case (state_q)
                ST_IDLE: begin
                    env_d = 17'd0;
                    if (tx_en) begin
                        // The ramp starts on the request sample itself.
                        env_d        = env_up;
                        cnt_d        = '0;
                        burst_done_d = 1'b0;
                        state_d      = (env_up == ENV_ONE) ? ST_ON : ST_UP;
                    end
                end
                ST_UP: begin
                    if (!tx_en) begin
                        go_down = 1'b1;
                    end else begin
                        env_d = env_up;
                        if (env_up == ENV_ONE) begin
                            cnt_d   = '0;
                            state_d = ST_ON;
                        end
                    end
                end
                ST_ON: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!tx_en) begin
                        go_down = 1'b1;
                    end else if (burst_hit) begin
                        go_down   = 1'b1;
                        burst_end = 1'b1;
                    end
                end
                ST_DOWN: begin
                    go_down   = 1'b1;
                    burst_end = burst_done_q;
                end
                ST_HOLD: begin
                    env_d = 17'd0;
                    if (!tx_en) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    env_d   = 17'd0;
                    state_d = ST_IDLE;
                end
            endcase

            if (go_down) begin
                env_d        = env_dn;
                burst_done_d = burst_end;
                if (env_dn == 17'd0) begin
                    done_d  = 1'b1;
                    state_d = (burst_end && tx_en) ? ST_HOLD : ST_IDLE;
                end else begin
                    state_d = ST_DOWN;
                end
            end
        end
    end

    assign env  = env_q;
    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule

// File: rtl/tx_da_shaper.sv
// TX DAC shaper top: envelope x gain, round and saturate to DW, offset-binary out.
// Optional build macro TX_DA_SHAPER_DITHER_EN swaps fixed rounding for LFSR dither.
module tx_da_shaper
    import tx_pkg::*;
#(
    parameter int DW    = 14,
    parameter int CNT_W = 16
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic [15:0]      pcm_in,
    input  logic             pcm_in_valid,
    input  logic             tx_en,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [15:0]      ramp_inc,
    input  logic [15:0]      gain,
    output logic [DW-1:0]    da_data,
    output logic             da_valid,
    output logic             busy,
    output logic             done,
    input  logic             err_clr,
    output logic             err
);

    localparam int            SH       = 16 - DW;
    localparam logic [DW-1:0] MIDSCALE = {1'b1, {(DW-1){1'b0}}};

    logic [16:0]        env;

    logic               v1_q, v2_q, da_valid_q;
    logic signed [15:0] p1_q, p1_d;
    logic signed [15:0] p2_q, p2_d;
    logic               sat2_q, sat2_d;
    logic [DW-1:0]      da_q, da_d;
    logic               err_q, err_d;

    logic signed [33:0] prod1, round1;
    logic signed [33:0] prod2, sh2, clip2;
    logic signed [33:0] rnd, sh3, clip3;
    logic               sat3;

    tx_env_gen #(
        .CNT_W(CNT_W)
    ) u_env (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .sample_valid(pcm_in_valid),
        .tx_en       (tx_en),
        .burst_len   (burst_len),
        .ramp_inc    (ramp_inc),
        .env         (env),
        .busy        (busy),
        .done        (done)
    );

`ifdef TX_DA_SHAPER_DITHER_EN
    localparam logic [15:0] DITHER_MASK = 16'((1 << SH) - 1);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (pcm_in_valid) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rnd = 34'(lfsr_q & DITHER_MASK);
`else
    localparam int RND_FIX = (1 << SH) >> 1;

    assign rnd = 34'(RND_FIX);
`endif

    always_comb begin
        // S1: envelope multiply; |env| <= 1.0 so the result always fits 16 bits.
        prod1 = 34'($signed(pcm_in)) * 34'($signed({1'b0, env}));
        round1 = prod1 + 34'sd16384;
        p1_d   = pcm_in_valid ? 16'(round1 >>> 15) : p1_q;

        // S2: gain up to ~2.0 can overflow, so clamp back to 16 bits.
        prod2  = 34'(p1_q) * 34'($signed({1'b0, gain}));
        sh2    = (prod2 + 34'sd16384) >>> 15;
        clip2  = sat_clip(sh2, 16);
        p2_d   = v1_q ? 16'(clip2) : p2_q;
        sat2_d = v1_q ? (clip2 != sh2) : sat2_q;

        // S3: round to DAC width, clamp, flip MSB for offset binary.
        sh3    = (34'(p2_q) + rnd) >>> SH;
        clip3  = sat_clip(sh3, DW);
        sat3   = (clip3 != sh3);
        da_d   = v2_q ? {~clip3[DW-1], clip3[DW-2:0]} : da_q;

        err_d  = err_clr ? 1'b0 : (err_q | (v2_q & (sat2_q | sat3)));
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            da_valid_q <= 1'b0;
            p1_q       <= '0;
            p2_q       <= '0;
            sat2_q     <= 1'b0;
            da_q       <= MIDSCALE;
            err_q      <= 1'b0;
        end else begin
            v1_q       <= pcm_in_valid;
            v2_q       <= v1_q;
            da_valid_q <= v2_q;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            sat2_q     <= sat2_d;
            da_q       <= da_d;
            err_q      <= err_d;
        end
    end

    assign da_data  = da_q;
    assign da_valid = da_valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_tx_da_shaper.sv
// Directed bench for tx_da_shaper (DW=14): ramp-up, saturation/err, reset, burst/HOLD, abort.
module tb_tx_da_shaper;

    localparam int DW    = 14;
    localparam int CNT_W = 16;

    logic             clk1 = 1'b0;
    logic             rst_n;
    logic [15:0]      pcm_in;
    logic             pcm_in_valid;
    logic             tx_en;
    logic [CNT_W-1:0] burst_len;
    logic [15:0]      ramp_inc;
    logic [15:0]      gain;
    logic [DW-1:0]    da_data;
    logic             da_valid;
    logic             busy;
    logic             done;
    logic             err_clr;
    logic             err;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk1 = ~clk1;

    tx_da_shaper #(
        .DW   (DW),
        .CNT_W(CNT_W)
    ) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .pcm_in      (pcm_in),
        .pcm_in_valid(pcm_in_valid),
        .tx_en       (tx_en),
        .burst_len   (burst_len),
        .ramp_inc    (ramp_inc),
        .gain        (gain),
        .da_data     (da_data),
        .da_valid    (da_valid),
        .busy        (busy),
        .done        (done),
        .err_clr     (err_clr),
        .err         (err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One sample: strobe on a negedge, then observe at the following three negedges.
    task automatic run_vec(input string tag, input logic [15:0] pcm, input logic tx,
                           input logic [15:0] ramp, input logic [15:0] blen,
                           input logic [15:0] g, input logic clr,
                           input logic [13:0] exp_da, input logic exp_done,
                           input logic exp_busy, input logic exp_err);
        @(negedge clk1);
        pcm_in       = pcm;
        tx_en        = tx;
        ramp_inc     = ramp;
        burst_len    = blen;
        gain         = g;
        pcm_in_valid = 1'b1;
        @(negedge clk1);
        pcm_in_valid = 1'b0;
        check_val({tag, ".busy"}, 32'(busy), 32'(exp_busy));
        check_val({tag, ".done"}, 32'(done), 32'(exp_done));
        @(negedge clk1);
        check_val({tag, ".early_valid"}, 32'(da_valid), 32'd0);
        check_val({tag, ".done_width"}, 32'(done), 32'd0);
        err_clr = clr;
        @(negedge clk1);
        err_clr = 1'b0;
        check_val({tag, ".valid"}, 32'(da_valid), 32'd1);
        check_val({tag, ".da"}, 32'(da_data), 32'(exp_da));
        check_val({tag, ".err"}, 32'(err), 32'(exp_err));
        $display("vec %-4s pcm=%04h tx=%0d da=%04h busy=%0d err=%0d", tag, pcm, tx, da_data, busy, err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        pcm_in       = 16'h0000;
        pcm_in_valid = 1'b0;
        tx_en        = 1'b0;
        burst_len    = 16'd0;
        ramp_inc     = 16'h2000;
        gain         = 16'h8000;
        err_clr      = 1'b0;

        #12;
        check_val("rst.da",    32'(da_data),  32'h2000);
        check_val("rst.valid", 32'(da_valid), 32'd0);
        check_val("rst.busy",  32'(busy),     32'd0);
        check_val("rst.done",  32'(done),     32'd0);
        check_val("rst.err",   32'(err),      32'd0);
        @(negedge clk1);
        rst_n = 1'b1;

        // Ramp-up with unity gain, env 0 -> 1.0 in 0x2000 steps
        //       tag   pcm       tx    ramp      blen   gain      clr   da        done  busy  err
        run_vec("A0", 16'h4000, 1'b1, 16'h2000, 16'd0, 16'h8000, 1'b0, 14'h2000, 1'b0, 1'b1, 1'b0);
        run_vec("A1", 16'h4000, 1'b1, 16'h2000, 16'd0, 16'h8000, 1'b0, 14'h2400, 1'b0, 1'b1, 1'b0);
        run_vec("A2", 16'h4000, 1'b1, 16'h2000, 16'd0, 16'h8000, 1'b0, 14'h2800, 1'b0, 1'b1, 1'b0);
        run_vec("A3", 16'h4000, 1'b1, 16'h2000, 16'd0, 16'h8000, 1'b0, 14'h2C00, 1'b0, 1'b1, 1'b0);
        run_vec("A4", 16'h4000, 1'b1, 16'h2000, 16'd0, 16'h8000, 1'b0, 14'h3000, 1'b0, 1'b1, 1'b0);
        run_vec("A5", 16'h4000, 1'b1, 16'h2000, 16'd0, 16'h8000, 1'b0, 14'h3000, 1'b0, 1'b1, 1'b0);

        // Saturation at gain ~2.0
        run_vec("A6", 16'h7FFF, 1'b1, 16'h2000, 16'd0, 16'hFFFF, 1'b0, 14'h3FFF, 1'b0, 1'b1, 1'b1);
        @(negedge clk1);
        err_clr = 1'b1;
        @(negedge clk1);
        err_clr = 1'b0;
        check_val("clr.err", 32'(err), 32'd0);
        run_vec("A7", 16'h8000, 1'b1, 16'h2000, 16'd0, 16'hFFFF, 1'b0, 14'h0000, 1'b0, 1'b1, 1'b1);
        // err_clr coincident with a new saturation: clear wins
        run_vec("A8", 16'h7FFF, 1'b1, 16'h2000, 16'd0, 16'hFFFF, 1'b1, 14'h3FFF, 1'b0, 1'b1, 1'b0);
        run_vec("A9", 16'h7FFF, 1'b1, 16'h2000, 16'd0, 16'hFFFF, 1'b0, 14'h3FFF, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset while ON with err set and da_valid high
        @(negedge clk1);
        pcm_in       = 16'h4000;
        pcm_in_valid = 1'b1;
        @(negedge clk1);
        pcm_in_valid = 1'b0;
        @(negedge clk1);
        @(negedge clk1);
        check_val("pre_rst.valid", 32'(da_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst.da",    32'(da_data),  32'h2000);
        check_val("mid_rst.valid", 32'(da_valid), 32'd0);
        check_val("mid_rst.busy",  32'(busy),     32'd0);
        check_val("mid_rst.err",   32'(err),      32'd0);
        @(negedge clk1);
        rst_n = 1'b1;

        // Burst of 4 with instant ramp, then HOLD until tx_en is seen low
        run_vec("B0",  16'h4000, 1'b1, 16'h0000, 16'd4, 16'h8000, 1'b0, 14'h2000, 1'b0, 1'b1, 1'b0);
        run_vec("B1",  16'h4000, 1'b1, 16'h0000, 16'd4, 16'h8000, 1'b0, 14'h3000, 1'b0, 1'b1, 1'b0);
        run_vec("B2",  16'h4000, 1'b1, 16'h0000, 16'd4, 16'h8000, 1'b0, 14'h3000, 1'b0, 1'b1, 1'b0);
        run_vec("B3",  16'h4000, 1'b1, 16'h0000, 16'd4, 16'h8000, 1'b0, 14'h3000, 1'b0, 1'b1, 1'b0);
        run_vec("B4",  16'h4000, 1'b1, 16'h0000, 16'd4, 16'h8000, 1'b0, 14'h3000, 1'b1, 1'b1, 1'b0);
        run_vec("B5",  16'h4000, 1'b1, 16'h0000, 16'd4, 16'h8000, 1'b0, 14'h2000, 1'b0, 1'b1, 1'b0);
        run_vec("B6",  16'h4000, 1'b1, 16'h0000, 16'd4, 16'h8000, 1'b0, 14'h2000, 1'b0, 1'b1, 1'b0);
        run_vec("B7",  16'h4000, 1'b0, 16'h0000, 16'd4, 16'h8000, 1'b0, 14'h2000, 1'b0, 1'b0, 1'b0);
        run_vec("B8",  16'h4000, 1'b1, 16'h0000, 16'd4, 16'h8000, 1'b0, 14'h2000, 1'b0, 1'b1, 1'b0);
        run_vec("B9",  16'hC000, 1'b1, 16'h0000, 16'd4, 16'h8000, 1'b0, 14'h1000, 1'b0, 1'b1, 1'b0);
        run_vec("B10", 16'h4000, 1'b0, 16'h0000, 16'd4, 16'h8000, 1'b0, 14'h3000, 1'b1, 1'b0, 1'b0);

        // Abort during ramp-up: env 0x4000 -> 0x2000 -> 0, then IDLE
        run_vec("C0", 16'h4000, 1'b1, 16'h2000, 16'd0, 16'h8000, 1'b0, 14'h2000, 1'b0, 1'b1, 1'b0);
        run_vec("C1", 16'h4000, 1'b1, 16'h2000, 16'd0, 16'h8000, 1'b0, 14'h2400, 1'b0, 1'b1, 1'b0);
        run_vec("C2", 16'h4000, 1'b0, 16'h2000, 16'd0, 16'h8000, 1'b0, 14'h2800, 1'b0, 1'b1, 1'b0);
        run_vec("C3", 16'h4000, 1'b0, 16'h2000, 16'd0, 16'h8000, 1'b0, 14'h2400, 1'b1, 1'b0, 1'b0);
        run_vec("C4", 16'h4000, 1'b0, 16'h2000, 16'd0, 16'h8000, 1'b0, 14'h2000, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
